// File: rtl/adf4351_pkg.sv
// Fixed PLL plan for the ADF4351: 25 MHz PFD, MOD 3125 (8 kHz VCO step), 2.2-4.4 GHz VCO.
// Shared constants, FSM encoding and register-packing helpers.
package adf4351_pkg;

  localparam logic [15:0] PFD_KHZ        = 16'd25000;
  localparam logic [12:0] MOD            = 13'd3125;
  localparam logic [22:0] VCO_MIN_KHZ    = 23'd2200000;
  localparam logic [22:0] VCO_MAX_KHZ    = 23'd4400000;
  localparam logic [22:0] LO_OFFSET_KHZ  = 23'd2000;
  localparam logic [2:0]  K_MAX          = 3'd6;
  localparam logic [22:0] TARGET_MIN_KHZ = VCO_MIN_KHZ >> K_MAX;

  localparam logic [31:0] R4_BASE    = 32'h008C803C;
  localparam logic [31:0] R0_DEFAULT = 32'h00500000;
  localparam logic [31:0] R4_DEFAULT = 32'h00AC803C;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    DIV,
    RND
  } state_t;

  // Smallest output-divider power k that lifts the target into the VCO band.
  function automatic logic [2:0] calc_k(input logic [22:0] target);
    logic [2:0] k;
    k = K_MAX;
    for (int i = int'(K_MAX); i >= 0; i--) begin
      if (({6'd0, target} << i) >= {6'd0, VCO_MIN_KHZ}) k = i[2:0];
    end
    return k;
  endfunction

  function automatic logic [31:0] pack_r0(input logic [15:0] int_val, input logic [11:0] frac_val);
    return {1'b0, int_val, frac_val, 3'b000};
  endfunction

  function automatic logic [31:0] pack_r4(input logic [2:0] k);
    logic [31:0] r;
    r = R4_BASE;
    r[22:20] = k;
    return r;
  endfunction

endpackage

// File: rtl/adf4351_freq_calc_if.sv
// Request/result bundle between a frequency source and adf4351_freq_calc.
interface adf4351_freq_calc_if;
  logic        CFG_EN;
  logic        LO_SET;
  logic [23:0] FREQ;
  logic [31:0] ADF_R0;
  logic [31:0] ADF_R4;
  logic        DONE;
  logic        ERR;
  logic        BUSY;

  modport master (
    output CFG_EN, LO_SET, FREQ,
    input  ADF_R0, ADF_R4, DONE, ERR, BUSY
  );

  modport slave (
    input  CFG_EN, LO_SET, FREQ,
    output ADF_R0, ADF_R4, DONE, ERR, BUSY
  );
endinterface

// File: rtl/adf_div25k.sv
// Restoring divide of a 23-bit VCO frequency by 25000, producing 8 quotient bits MSB first.
// start loads the operand; last marks the final iteration; done pulses when quo/rem are valid.
module adf_div25k
  import adf4351_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [22:0] dividend,
  output logic        last,
  output logic        done,
  output logic [7:0]  quo,
  output logic [15:0] rem
);

  logic        active;
  logic [2:0]  cnt;
  logic [7:0]  low_bits;
  logic [15:0] rem_q;
  logic [7:0]  quo_q;
  logic        done_q;
  logic [15:0] trial;
  logic        fits;

  // The upper 15 bits of any in-band VCO are already below 25000, so only 8 bits need dividing.
  assign trial = {rem_q[14:0], low_bits[cnt]};
  assign fits  = (trial >= PFD_KHZ);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= 3'd0;
      low_bits <= 8'd0;
      rem_q    <= 16'd0;
      quo_q    <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q    <= {1'b0, dividend[22:8]};
        low_bits <= dividend[7:0];
        quo_q    <= 8'd0;
        cnt      <= 3'd7;
        active   <= 1'b1;
      end else if (active) begin
        if (fits) begin
          rem_q      <= trial - PFD_KHZ;
          quo_q[cnt] <= 1'b1;
        end else begin
          rem_q <= trial;
        end
        if (cnt == 3'd0) begin
          active <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  assign last = active && (cnt == 3'd0);
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/adf4351_freq_calc.sv
// Requested kHz frequency -> ADF4351 R0 (INT/FRAC) and R4 (divider select) words.
// Fixed 10-clock latency: range select, 8-step divide, round; new requests ignored while busy.
module adf4351_freq_calc
  import adf4351_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  adf4351_freq_calc_if.slave bus
);

  state_t      state, state_nxt;
  logic [22:0] target;
  logic [2:0]  ksel;
  logic [31:0] adf_r0_q, adf_r4_q;
  logic        done_q, err_q;

  logic        load_target, div_start, load_out, done_nxt, err_nxt;
  logic        in_range;
  logic [2:0]  k_calc;
  logic [22:0] vco_calc;
  logic        div_last, div_done;
  logic [7:0]  div_quo;
  logic [15:0] div_rem;
  logic [12:0] frac_round;
  logic        frac_wrap;
  logic [15:0] int_val;
  logic [11:0] frac_val;

  assign in_range = (target >= TARGET_MIN_KHZ) && (target <= VCO_MAX_KHZ);
  assign k_calc   = calc_k(target);
  assign vco_calc = target << k_calc;

  adf_div25k u_div (
    .clk      (CLK),
    .rst      (RST),
    .start    (div_start),
    .dividend (vco_calc),
    .last     (div_last),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  // Half-up rounding of the remainder to 8 kHz steps can land on MOD; carry it into INT.
  assign frac_round = 13'((div_rem + 16'd4) >> 3);
  assign frac_wrap  = (frac_round == MOD);
  assign frac_val   = frac_wrap ? 12'd0 : frac_round[11:0];
  assign int_val    = {8'd0, div_quo} + {15'd0, frac_wrap};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_target = 1'b0;
    div_start   = 1'b0;
    load_out    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CFG_EN) begin
          load_target = 1'b1;
          state_nxt   = SEL;
        end
      end
      SEL: begin
        if (!in_range) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          div_start = 1'b1;
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (div_last) state_nxt = RND;
      end
      RND: begin
        if (div_done) begin
          load_out  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      target   <= 23'd0;
      ksel     <= 3'd0;
      adf_r0_q <= R0_DEFAULT;
      adf_r4_q <= R4_DEFAULT;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (load_target) target <= 23'(bus.FREQ + (bus.LO_SET ? {1'b0, LO_OFFSET_KHZ} : 24'd0));
      if (div_start)   ksel   <= k_calc;
      if (load_out) begin
        adf_r0_q <= pack_r0(int_val, frac_val);
        adf_r4_q <= pack_r4(ksel);
      end
    end
  end

  assign bus.ADF_R0 = adf_r0_q;
  assign bus.ADF_R4 = adf_r4_q;
  assign bus.DONE   = done_q;
  assign bus.ERR    = err_q;
  assign bus.BUSY   = (state != IDLE);

endmodule

// File: tb/tb_adf4351_freq_calc.sv
// Bench for adf4351_freq_calc: directed vector table, control corner sequences,
// and randomized requests against an arithmetic model of the frequency plan.
module tb_adf4351_freq_calc;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  adf4351_freq_calc_if bus ();

  adf4351_freq_calc dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned freq;
    bit          lo;
    bit          exp_err;
    logic [31:0] r0;
    logic [31:0] r4;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Plain-arithmetic model of the plan: double until in the VCO band, divide by the PFD,
  // round the remainder to the nearest 8 kHz step.
  function automatic void model(input int unsigned freq, input bit lo, output bit err,
                                output logic [31:0] r0, output logic [31:0] r4);
    longint t, vco, q, rem, f;
    int     k;
    t = (longint'(freq) + (lo ? 2000 : 0)) % 8388608;
    r0 = '0;
    r4 = '0;
    err = 1'b0;
    if (t < 34375 || t > 4400000) begin
      err = 1'b1;
      return;
    end
    k = 0;
    vco = t;
    while (vco < 2200000) begin
      vco = vco * 2;
      k++;
    end
    q = vco / 25000;
    rem = vco % 25000;
    f = (rem + 4) / 8;
    if (f == 3125) begin
      q = q + 1;
      f = 0;
    end
    r0 = 32'(q * 32768 + f * 8);
    r4 = 32'h008C803C | (32'(k) << 20);
  endfunction

  // Issues one request; CFG_EN stays high through edge 'hold'. Observes edges 0..14.
  task automatic run(input int unsigned freq, input bit lo, input int hold,
                     output int done_edge, output int err_edge,
                     output int done_n, output int err_n, output logic [14:0] busy_v);
    done_edge = -1;
    err_edge  = -1;
    done_n    = 0;
    err_n     = 0;
    busy_v    = '0;
    @(negedge clk);
    bus.CFG_EN = 1'b1;
    bus.FREQ   = 24'(freq);
    bus.LO_SET = lo;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      busy_v[n] = bus.BUSY;
      if (bus.DONE) begin
        done_n++;
        if (done_edge < 0) done_edge = n;
      end
      if (bus.ERR) begin
        err_n++;
        if (err_edge < 0) err_edge = n;
      end
      if (n == 0) begin
        bus.FREQ   = 24'd34375;
        bus.LO_SET = ~lo;
      end
      if (n >= hold) bus.CFG_EN = 1'b0;
    end
  endtask

  task automatic check_txn(input string tag, input bit exp_err, input int de, input int ee,
                           input int dn, input int en, input logic [14:0] bv);
    if (exp_err) check({tag, " err_edge"}, ee, 1);
    else         check({tag, " done_edge"}, de, 10);
    check({tag, " pulses"}, dn + en, 1);
    check({tag, " busy"}, {17'd0, bv}, exp_err ? 32'h0001 : 32'h03FF);
  endtask

  vec_t        vecs[10];
  logic [31:0] exp_r0, exp_r4;
  int          de, ee, dn, en;
  logic [14:0] bv;

  initial begin
    vecs[0] = '{1000000, 1'b0, 1'b0, 32'h00500000, 32'h00AC803C};
    vecs[1] = '{1000000, 1'b1, 1'b0, 32'h00501F40, 32'h00AC803C};
    vecs[2] = '{4400000, 1'b0, 1'b0, 32'h00580000, 32'h008C803C};
    vecs[3] = '{34375,   1'b0, 1'b0, 32'h002C0000, 32'h00EC803C};
    vecs[4] = '{2200000, 1'b0, 1'b0, 32'h002C0000, 32'h008C803C};
    vecs[5] = '{2224997, 1'b0, 1'b0, 32'h002C8000, 32'h008C803C};
    vecs[6] = '{4400001, 1'b0, 1'b1, 32'h002C8000, 32'h008C803C};
    vecs[7] = '{34374,   1'b0, 1'b1, 32'h002C8000, 32'h008C803C};
    vecs[8] = '{4399000, 1'b1, 1'b1, 32'h002C8000, 32'h008C803C};
    vecs[9] = '{32375,   1'b1, 1'b0, 32'h002C0000, 32'h00EC803C};

    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    bus.CFG_EN = 1'b0;
    bus.LO_SET = 1'b0;
    bus.FREQ   = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset r0", bus.ADF_R0, 32'h00500000);
    check("reset r4", bus.ADF_R4, 32'h00AC803C);
    check("reset done", {31'd0, bus.DONE}, 0);
    check("reset err", {31'd0, bus.ERR}, 0);
    check("reset busy", {31'd0, bus.BUSY}, 0);

    foreach (vecs[i]) begin
      run(vecs[i].freq, vecs[i].lo, 0, de, ee, dn, en, bv);
      check_txn($sformatf("vec%0d", i), vecs[i].exp_err, de, ee, dn, en, bv);
      check($sformatf("vec%0d r0", i), bus.ADF_R0, vecs[i].r0);
      check($sformatf("vec%0d r4", i), bus.ADF_R4, vecs[i].r4);
    end

    // CFG_EN held through the whole computation, with FREQ changing after acceptance.
    run(1000000, 1'b0, 10, de, ee, dn, en, bv);
    check_txn("hold", 1'b0, de, ee, dn, en, bv);
    check("hold done_cnt", dn, 1);
    check("hold r0", bus.ADF_R0, 32'h00500000);
    check("hold r4", bus.ADF_R4, 32'h00AC803C);

    // Back-to-back: a request raised in the DONE cycle is taken on the next edge.
    @(negedge clk);
    bus.CFG_EN = 1'b1;
    bus.FREQ   = 24'd4400000;
    bus.LO_SET = 1'b0;
    @(posedge clk);
    #1;
    bus.CFG_EN = 1'b0;
    de = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) begin
        de = n;
        break;
      end
    end
    check("b2b first done_edge", de, 10);
    check("b2b first r0", bus.ADF_R0, 32'h00580000);
    bus.CFG_EN = 1'b1;
    bus.FREQ   = 24'd34375;
    @(posedge clk);
    #1;
    bus.CFG_EN = 1'b0;
    check("b2b accepted busy", {31'd0, bus.BUSY}, 1);
    de = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) begin
        de = n;
        break;
      end
    end
    check("b2b second done_edge", de, 10);
    check("b2b second r0", bus.ADF_R0, 32'h002C0000);
    check("b2b second r4", bus.ADF_R4, 32'h00EC803C);

    // Reset at edge 5 aborts the computation and restores the default words.
    @(negedge clk);
    bus.CFG_EN = 1'b1;
    bus.FREQ   = 24'd2224997;
    bus.LO_SET = 1'b0;
    @(posedge clk);
    #1;
    bus.CFG_EN = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort r0", bus.ADF_R0, 32'h00500000);
    check("abort r4", bus.ADF_R4, 32'h00AC803C);
    check("abort busy", {31'd0, bus.BUSY}, 0);
    dn = 0;
    en = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) dn++;
      if (bus.ERR) en++;
    end
    check("abort pulses", dn + en, 0);
    check("abort r0 hold", bus.ADF_R0, 32'h00500000);
    exp_r0 = 32'h00500000;
    exp_r4 = 32'h00AC803C;

    for (int i = 0; i < 40; i++) begin
      int unsigned f;
      bit          lo, m_err;
      logic [31:0] m_r0, m_r4;
      int          off;
      lo  = 1'($urandom_range(0, 1));
      off = lo ? 2000 : 0;
      case ($urandom_range(0, 3))
        0:       f = $urandom_range(20000, 4500000);
        1:       f = 34375 + $urandom_range(0, 40) - 20 - off;
        2:       f = 4400000 + $urandom_range(0, 40) - 20 - off;
        default: f = (2200000 >> $urandom_range(0, 6)) + $urandom_range(0, 6) - 3 - off;
      endcase
      model(f, lo, m_err, m_r0, m_r4);
      run(f, lo, 0, de, ee, dn, en, bv);
      if (!m_err) begin
        exp_r0 = m_r0;
        exp_r4 = m_r4;
      end
      check_txn($sformatf("rand%0d f=%0d lo=%0d", i, f, lo), m_err, de, ee, dn, en, bv);
      check($sformatf("rand%0d r0", i), bus.ADF_R0, exp_r0);
      check($sformatf("rand%0d r4", i), bus.ADF_R4, exp_r4);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/adf4351_freq_calc.md
# adf4351_freq_calc

- Converts a requested RF frequency in kHz into ADF4351 R0 (INT/FRAC) and R4 (RF divider select) register words.
- Sits directly upstream of the ADF4351 register-write sequencer. One instance per synthesizer: RF with LO_SET=0, LO with LO_SET=1.
- Fixed PLL plan: PFD 25 MHz, MOD 3125 (8 kHz VCO step), VCO 2.2–4.4 GHz, prescaler 8/9.
- Computation is a fixed-latency sequential pipeline: range select, 8-step restoring divide, round.

## Interface
- No parameters. All plan constants are fixed in the shared package.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CFG_EN  in  1  start request; sampled only while idle.
- LO_SET  in  1  when 1, target = FREQ + 2000 kHz (LO offset).
- FREQ  in  24  requested output frequency, kHz.
- ADF_R0  out  32  register 0 word {1'b0, INT[15:0], FRAC[11:0], 3'b000}.
- ADF_R4  out  32  register 4 word: 32'h008C803C with bits[22:20] = divider select k.
- DONE  out  1  one-cycle pulse; ADF_R0/ADF_R4 are updated in the same cycle.
- ERR  out  1  one-cycle pulse; target out of range, outputs unchanged.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, SEL, DIV, RND.
- IDLE:
  - On CFG_EN, register target = FREQ + (LO_SET ? 2000 : 0), computed 23 bits wide.
  - Go to SEL.
- SEL, out of range:
  - Condition: target < 34375 or target > 4400000.
  - ERR <= 1, return to IDLE.
- SEL, in range:
  - k = smallest value in 0..6 with (target << k) >= 2200000.
  - vco <= target << k (23 bits); ksel <= k.
  - Remainder register rem <= vco[22:8] (16 bits); quotient q <= 0; counter <= 7.
  - Go to DIV.
- DIV: 8 iterations, MSB first, bits 7 down to 0.
  - t = {rem[14:0], vco[i]}.
  - If t >= 25000: rem <= t - 25000 and q[i] <= 1; else rem <= t.
  - After bit 0, go to RND.
- RND:
  - f = (rem + 4) >> 3 (round half-up).
  - If f == 3125: FRAC = 0 and INT = q + 1. Otherwise FRAC = f and INT = q.
  - Load ADF_R0 and ADF_R4, DONE <= 1, go to IDLE.
- CFG_EN outside IDLE is ignored; it is not queued.
- FREQ and LO_SET are sampled only in the cycle that accepts CFG_EN.
- Reset values:
  - ADF_R0 = 32'h00500000, ADF_R4 = 32'h00AC803C (1000 MHz defaults).
  - DONE = ERR = BUSY = 0; state = IDLE.
- RST asserted mid-computation aborts it: no DONE or ERR pulse, outputs return to reset values.

## Timing
- Let edge 0 be the clock edge that accepts CFG_EN.
- BUSY is high after edges 0 through 9 and low after edge 10.
- ERR is high for the one cycle after edge 1.
- DONE is high for the one cycle after edge 10. ADF_R0/ADF_R4 take new values at edge 10 and hold until the next DONE or RST.
- Fixed latency of 10 clocks, independent of frequency.
- Back-to-back requests: a CFG_EN asserted in the DONE cycle is accepted, because the FSM is already in IDLE.
- Boundary cases:
  - target == 2200000 gives k = 0.
  - target == 34375 gives k = 6.
  - target == 4400000 is valid with k = 0.

## Structure
- Package adf4351_pkg holds:
  - PFD_KHZ = 25000, MOD = 3125
  - VCO_MIN_KHZ = 2200000, VCO_MAX_KHZ = 4400000
  - LO_OFFSET_KHZ = 2000
  - R4_BASE = 32'h008C803C, R0_DEFAULT, R4_DEFAULT
  - the state enum
- Sub-module adf_div25k: 8-iteration restoring divider with start/done handshake and quotient/remainder outputs. The top keeps range select, rounding and register packing.

## Test plan
- FREQ=1000000, LO_SET=0, CFG_EN pulse -> DONE after edge 10, ADF_R0=32'h00500000, ADF_R4=32'h00AC803C.
- FREQ=1000000, LO_SET=1 -> ADF_R0=32'h00501F40 (INT 160, FRAC 1000), ADF_R4=32'h00AC803C.
- Range edges:
  - FREQ=4400000 -> ADF_R0=32'h00580000, ADF_R4=32'h008C803C.
  - FREQ=34375 -> ADF_R0=32'h002C0000, ADF_R4=32'h00EC803C.
- Rounding carry: FREQ=2224997, LO_SET=0 -> remainder 24997 rounds to 3125 -> ADF_R0=32'h002C8000 (INT 89, FRAC 0).
- FREQ=4400001 or FREQ=34374 -> ERR pulse after edge 1, no DONE, ADF_R0/ADF_R4 unchanged.
- Control cases:
  - CFG_EN held during computation -> ignored.
  - RST asserted at edge 5 -> outputs return to reset values, no DONE pulse.
